// File: rtl/read_master_pkg.sv
// Shared constants and helpers for the Avalon-MM read and write masters.
package read_master_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    localparam int DATAWIDTH_DEF       = 32;
    localparam int BYTEENABLEWIDTH_DEF = 4;
    localparam int ADDRESSWIDTH_DEF    = 32;
    localparam int FIFODEPTH_DEF       = 32;
    localparam int FIFODEPTH_LOG2_DEF  = clog2(FIFODEPTH_DEF);

endpackage

// File: rtl/read_master_if.sv
// Avalon-MM read bus between the read master and its slave.
interface read_master_if
    import read_master_pkg::*;
#(
    parameter int DATAWIDTH       = DATAWIDTH_DEF,
    parameter int BYTEENABLEWIDTH = BYTEENABLEWIDTH_DEF,
    parameter int ADDRESSWIDTH    = ADDRESSWIDTH_DEF
) ();

    logic [ADDRESSWIDTH-1:0]    master_address;
    logic                       master_read;
    logic [BYTEENABLEWIDTH-1:0] master_byteenable;
    logic [DATAWIDTH-1:0]       master_readdata;
    logic                       master_readdatavalid;
    logic                       master_waitrequest;

    modport master (
        output master_address,
        output master_read,
        output master_byteenable,
        input  master_readdata,
        input  master_readdatavalid,
        input  master_waitrequest
    );

    modport slave (
        input  master_address,
        input  master_read,
        input  master_byteenable,
        output master_readdata,
        output master_readdatavalid,
        output master_waitrequest
    );

endinterface

// File: rtl/master_fifo.sv
// Synchronous show-ahead FIFO; the head word is visible on read_data whenever empty is low.
module master_fifo
    import read_master_pkg::*;
#(
    parameter int WIDTH      = DATAWIDTH_DEF,
    parameter int DEPTH      = FIFODEPTH_DEF,
    parameter int DEPTH_LOG2 = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write,
    input  logic [WIDTH-1:0]      write_data,
    input  logic                  read,
    output logic [WIDTH-1:0]      read_data,
    output logic [DEPTH_LOG2:0]   used,
    output logic                  empty,
    output logic                  full
);

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   USED_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   USED_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty     = (used == '0);
    assign full      = (used == USED_MAX);
    assign do_pop    = read & ~empty;
    assign do_push   = write & (~full | do_pop);
    assign read_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   used <= used + USED_ONE;
                2'b01:   used <= used - USED_ONE;
                default: used <= used;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= write_data;
        end
    end

endmodule

// File: rtl/read_master.sv
// Avalon-MM burstless read master: issues word reads over a programmed range and
// buffers returned data for a show-ahead user port.
module read_master
    import read_master_pkg::*;
#(
    parameter int DATAWIDTH       = DATAWIDTH_DEF,
    parameter int BYTEENABLEWIDTH = BYTEENABLEWIDTH_DEF,
    parameter int ADDRESSWIDTH    = ADDRESSWIDTH_DEF,
    parameter int FIFODEPTH       = FIFODEPTH_DEF,
    parameter int FIFODEPTH_LOG2  = FIFODEPTH_LOG2_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0] control_read_base,
    input  logic [ADDRESSWIDTH-1:0] control_read_length,
    input  logic                    control_go,
    output logic                    control_done,
    output logic                    control_early_done,

    input  logic                    user_read_buffer,
    output logic [DATAWIDTH-1:0]    user_buffer_data,
    output logic                    user_data_available,

    read_master_if.master           avm
);

    localparam logic [ADDRESSWIDTH-1:0]   STEP         = ADDRESSWIDTH'(BYTEENABLEWIDTH);
    localparam logic [FIFODEPTH_LOG2:0]   PEND_ONE     = 1;
    localparam logic [FIFODEPTH_LOG2+1:0] CREDIT_LIMIT = (FIFODEPTH_LOG2 + 2)'(FIFODEPTH);

    logic [ADDRESSWIDTH-1:0]   address;
    logic [ADDRESSWIDTH-1:0]   length;
    logic                      fixed;
    logic [FIFODEPTH_LOG2:0]   pending;
    logic [FIFODEPTH_LOG2:0]   fifo_used;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [FIFODEPTH_LOG2+1:0] credit_used;
    logic                      read_accept;
    logic                      beat_valid;
    logic                      go_accept;

    // Buffered plus in-flight words must never exceed the buffer, so a read is
    // only issued when its returning beat is guaranteed a slot.
    assign credit_used           = {1'b0, fifo_used} + {1'b0, pending};
    assign avm.master_read       = (length != '0) && (credit_used < CREDIT_LIMIT);
    assign avm.master_address    = address;
    assign avm.master_byteenable = '1;

    assign read_accept        = avm.master_read & ~avm.master_waitrequest;
    // Beats arriving with nothing outstanding belong to reads discarded by a reset.
    assign beat_valid         = avm.master_readdatavalid & (pending != '0);
    assign control_early_done = (length == '0);
    assign control_done       = control_early_done & (pending == '0);
    assign go_accept          = control_go & control_done;
    assign user_data_available = ~fifo_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address <= '0;
            length  <= '0;
            fixed   <= 1'b0;
        end else if (go_accept) begin
            address <= control_read_base;
            length  <= control_read_length;
            fixed   <= control_fixed_location;
        end else if (read_accept) begin
            if (!fixed) begin
                address <= address + STEP;
            end
            length <= (length < STEP) ? '0 : length - STEP;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            case ({read_accept, beat_valid})
                2'b10:   pending <= pending + PEND_ONE;
                2'b01:   pending <= pending - PEND_ONE;
                default: pending <= pending;
            endcase
        end
    end

    master_fifo #(
        .WIDTH      (DATAWIDTH),
        .DEPTH      (FIFODEPTH),
        .DEPTH_LOG2 (FIFODEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .write      (beat_valid),
        .write_data (avm.master_readdata),
        .read       (user_read_buffer),
        .read_data  (user_buffer_data),
        .used       (fifo_used),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        beat_valid |-> (!fifo_full || user_read_buffer));

endmodule

// File: tb/tb_read_master.sv
// Directed bench for read_master with a latency-2 Avalon slave model and a popping consumer.
module tb_read_master;

    localparam int DW = 32, BEW = 4, AW = 32, DEPTH = 4, DEPTH_LOG2 = 2;

    typedef struct {
        logic        fixed;
        logic [31:0] base;
        logic [31:0] len;
        int          exp_reads;
        int          stall_idx;
        int          stall_len;
        logic [31:0] stall_len_exp;
    } xfer_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          control_fixed_location = 1'b0;
    logic [AW-1:0] control_read_base = '0;
    logic [AW-1:0] control_read_length = '0;
    logic          control_go = 1'b0;
    logic          control_done;
    logic          control_early_done;
    logic          user_read_buffer = 1'b0;
    logic [DW-1:0] user_buffer_data;
    logic          user_data_available;

    read_master_if #(.DATAWIDTH(DW), .BYTEENABLEWIDTH(BEW), .ADDRESSWIDTH(AW)) bus ();

    read_master #(
        .DATAWIDTH(DW), .BYTEENABLEWIDTH(BEW), .ADDRESSWIDTH(AW),
        .FIFODEPTH(DEPTH), .FIFODEPTH_LOG2(DEPTH_LOG2)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .control_fixed_location (control_fixed_location),
        .control_read_base      (control_read_base),
        .control_read_length    (control_read_length),
        .control_go             (control_go),
        .control_done           (control_done),
        .control_early_done     (control_early_done),
        .user_read_buffer       (user_read_buffer),
        .user_buffer_data       (user_buffer_data),
        .user_data_available    (user_data_available),
        .avm                    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, acc_total = 0, last_rdv_cyc = -1;
    int pops_req = 0, pops_done = 0;
    int stall_at = -1, stall_len = 0, stall_used = 0, last_stall_at = -1;
    logic [31:0] stall_addr_exp = '0, stall_length_exp = '0;
    logic pop_en = 1'b0, pop_force = 1'b0;
    logic [31:0] acc_addr[$];
    logic [31:0] rx[$];
    int          acc_cyc[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Slave model and consumer, both acting on the falling edge.
    initial begin : slave
        logic pv0, pv1, both_prev, wr, acc;
        logic [31:0] pd0, pd1;
        logic [DEPTH_LOG2:0] pend_prev;
        pv0 = 0; pv1 = 0; pd0 = '0; pd1 = '0; both_prev = 0; pend_prev = '0;
        bus.master_waitrequest = 1'b0;
        bus.master_readdatavalid = 1'b0;
        bus.master_readdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (stall_at != last_stall_at) begin
                stall_used = 0;
                last_stall_at = stall_at;
            end
            wr = 1'b0;
            if (stall_used < stall_len && (stall_used > 0 || (bus.master_read && acc_total == stall_at))) begin
                wr = 1'b1;
                stall_used++;
                check("stall_read_held", {31'b0, bus.master_read}, 1);
                check("stall_addr", bus.master_address, stall_addr_exp);
                check("stall_length", dut.length, stall_length_exp);
            end
            bus.master_waitrequest = wr;
            acc = bus.master_read & ~wr;
            if (both_prev) check("pending_same_cycle", {29'b0, dut.pending}, {29'b0, pend_prev});
            bus.master_readdatavalid = pv1;
            bus.master_readdata = pd1;
            if (pv1) last_rdv_cyc = cyc;
            both_prev = acc & pv1 & reset_n;
            pend_prev = dut.pending;
            pv1 = pv0;
            pd1 = pd0;
            pv0 = acc;
            pd0 = {8'hD0, 8'(acc_total), bus.master_address[15:0]};
            if (acc) begin
                acc_addr.push_back(bus.master_address);
                acc_cyc.push_back(cyc);
                acc_total++;
            end
            if (pop_force) begin
                user_read_buffer = 1'b1;
            end else if (user_data_available && (pop_en || pops_done < pops_req)) begin
                user_read_buffer = 1'b1;
                rx.push_back(user_buffer_data);
                if (!pop_en) pops_done++;
            end else begin
                user_read_buffer = 1'b0;
            end
        end
    end

    task automatic start_go(input logic fixed, input logic [31:0] base, input logic [31:0] len);
        control_fixed_location = fixed;
        control_read_base = base;
        control_read_length = len;
        control_go = 1'b1;
        tick();
        control_go = 1'b0;
    endtask

    task automatic run_xfer(input xfer_t r, input string tag);
        int a0, r0, seq0, n, done_cyc, avail_cyc;
        logic [31:0] ea;
        a0 = acc_addr.size(); r0 = rx.size(); seq0 = acc_total;
        if (r.stall_len > 0) begin
            stall_addr_exp = r.fixed ? r.base : r.base + BEW * r.stall_idx;
            stall_length_exp = r.stall_len_exp;
            stall_len = r.stall_len;
            stall_at = seq0 + r.stall_idx;
        end
        start_go(r.fixed, r.base, r.len);
        check({tag, "_busy"}, {31'b0, control_done}, 0);
        check({tag, "_early_busy"}, {31'b0, control_early_done}, 0);
        n = 0; done_cyc = -1; avail_cyc = -1;
        while (n < 300 && !(control_done && (rx.size() - r0) == r.exp_reads)) begin
            tick();
            n++;
            if (control_done && done_cyc < 0) done_cyc = cyc;
            if (user_data_available && avail_cyc < 0) avail_cyc = cyc;
        end
        check({tag, "_timeout"}, {31'b0, n < 300}, 1);
        check({tag, "_reads"}, acc_addr.size() - a0, r.exp_reads);
        for (int i = 0; i < r.exp_reads && a0 + i < acc_addr.size(); i++) begin
            ea = r.fixed ? r.base : r.base + BEW * i;
            check($sformatf("%s_addr%0d", tag, i), acc_addr[a0 + i], ea);
            if (r0 + i < rx.size())
                check($sformatf("%s_data%0d", tag, i), rx[r0 + i], {8'hD0, 8'(seq0 + i), ea[15:0]});
        end
        check({tag, "_rx_count"}, rx.size() - r0, r.exp_reads);
        check({tag, "_done_timing"}, done_cyc, last_rdv_cyc + 1);
        if (a0 < acc_cyc.size()) check({tag, "_first_avail"}, avail_cyc, acc_cyc[a0] + 3);
        check({tag, "_early_done"}, {31'b0, control_early_done}, 1);
        if (r.stall_len > 0) check({tag, "_stall_cycles"}, stall_used, r.stall_len);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, {31'b0, control_done}, 1);
        check({tag, "_early_done"}, {31'b0, control_early_done}, 1);
        check({tag, "_master_read"}, {31'b0, bus.master_read}, 0);
        check({tag, "_avail"}, {31'b0, user_data_available}, 0);
    endtask

    initial begin : main
        xfer_t tbl[7];
        int a0, r0, seq0, n;
        tbl[0] = '{1'b0, 32'h100,  32'd16, 4,  0, 0, 32'd0};
        tbl[1] = '{1'b1, 32'h40,   32'd10, 3,  0, 0, 32'd0};
        tbl[2] = '{1'b0, 32'h200,  32'd4,  1,  0, 0, 32'd0};
        tbl[3] = '{1'b0, 32'h300,  32'd7,  2,  0, 0, 32'd0};
        tbl[4] = '{1'b0, 32'h400,  32'd3,  1,  0, 0, 32'd0};
        tbl[5] = '{1'b0, 32'h1000, 32'd40, 10, 0, 0, 32'd0};
        tbl[6] = '{1'b0, 32'h500,  32'd16, 4,  1, 5, 32'd12};

        tick();
        tick();
        check_reset_outputs("rst");
        check("rst_byteenable", {28'b0, bus.master_byteenable}, 32'hF);
        reset_n = 1'b1;
        tick();

        pop_force = 1'b1;
        tick();
        pop_force = 1'b0;
        tick();
        check("empty_pop_avail", {31'b0, user_data_available}, 0);
        check("empty_pop_used", {29'b0, dut.u_fifo.used}, 0);

        pop_en = 1'b1;
        for (int i = 0; i < 7; i++) run_xfer(tbl[i], $sformatf("x%0d", i));

        // Credit limit with the consumer idle.
        pop_en = 1'b0;
        a0 = acc_addr.size(); r0 = rx.size(); seq0 = acc_total;
        start_go(1'b0, 32'h800, 32'd64);
        repeat (20) tick();
        check("credit_reads", acc_addr.size() - a0, 4);
        check("credit_hold", {31'b0, bus.master_read}, 0);
        check("credit_avail", {31'b0, user_data_available}, 1);
        check("credit_head", user_buffer_data, {8'hD0, 8'(seq0), 16'h0800});
        pops_req++;
        repeat (20) tick();
        check("credit_release", acc_addr.size() - a0, 5);
        check("credit_hold2", {31'b0, bus.master_read}, 0);
        check("credit_pop_count", rx.size() - r0, 1);
        if (rx.size() > r0) check("credit_pop_data", rx[r0], {8'hD0, 8'(seq0), 16'h0800});
        check("credit_head2", user_buffer_data, {8'hD0, 8'(seq0 + 1), 16'h0804});

        // Reset with a full buffer and an unfinished transfer.
        reset_n = 1'b0;
        tick();
        check_reset_outputs("flush");
        reset_n = 1'b1;
        tick();
        check("flush_after_avail", {31'b0, user_data_available}, 0);

        // A second go while busy must not disturb the running transfer.
        pop_en = 1'b1;
        a0 = acc_addr.size(); r0 = rx.size();
        start_go(1'b0, 32'h900, 32'd16);
        tick();
        start_go(1'b0, 32'hA00, 32'd8);
        n = 0;
        while (n < 200 && !(control_done && (rx.size() - r0) == 4)) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check("busy_go_timeout", {31'b0, n < 200}, 1);
        check("busy_go_reads", acc_addr.size() - a0, 4);
        if (acc_addr.size() >= a0 + 4) begin
            check("busy_go_first", acc_addr[a0], 32'h900);
            check("busy_go_last", acc_addr[a0 + 3], 32'h90C);
        end
        check("busy_go_done", {31'b0, control_done}, 1);

        // Reset while beats are still in flight; late beats must be dropped.
        pop_en = 1'b0;
        a0 = acc_addr.size();
        start_go(1'b0, 32'hB00, 32'd64);
        tick();
        reset_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
        check("midrst_inflight", acc_addr.size() - a0, 2);
        reset_n = 1'b1;
        repeat (5) tick();
        check("late_beat_avail", {31'b0, user_data_available}, 0);
        check("late_beat_done", {31'b0, control_done}, 1);
        check("late_beat_pending", {29'b0, dut.pending}, 0);
        check("late_beat_reads", acc_addr.size() - a0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/read_master.md
READ_MASTER -- requirements
Module: read_master

Interface
REQ-001 Parameters SHALL be: DATAWIDTH, default 32, data bus width; BYTEENABLEWIDTH, default 4, bytes per word; ADDRESSWIDTH, default 32, address and length width; FIFODEPTH, default 32, buffer words; FIFODEPTH_LOG2, default 5, log2(FIFODEPTH).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 control_fixed_location  in  1  when 1, the address does not increment; sampled on control_go.
REQ-005 control_read_base  in  ADDRESSWIDTH  word-aligned start byte address.
REQ-006 control_read_length  in  ADDRESSWIDTH  transfer length in bytes.
REQ-007 control_go  in  1  single-cycle start pulse.
REQ-008 control_done  out  1  high when no reads are outstanding and length is 0.
REQ-009 control_early_done  out  1  high when length is 0, meaning all reads are issued.
REQ-010 user_read_buffer  in  1  pops one word from the buffer.
REQ-011 user_buffer_data  out  DATAWIDTH  show-ahead head of the buffer.
REQ-012 user_data_available  out  1  buffer not empty.
REQ-013 master_address  out  ADDRESSWIDTH  Avalon-MM read address.
REQ-014 master_read  out  1  Avalon-MM read request.
REQ-015 master_byteenable  out  BYTEENABLEWIDTH  constant all ones.
REQ-016 master_readdata  in  DATAWIDTH  returned read data.
REQ-017 master_readdatavalid  in  1  master_readdata is valid this cycle.
REQ-018 master_waitrequest  in  1  slave stall; holds the current request.

Function
REQ-019 control_go SHALL be accepted only while control_done=1. On acceptance: address <= control_read_base, length <= control_read_length, fixed flag <= control_fixed_location. control_go while control_done=0 SHALL be ignored.
REQ-020 master_read SHALL equal (length != 0) & (fifo_used + pending < FIFODEPTH).
REQ-021 A read is accepted when master_read=1 and master_waitrequest=0. On acceptance the address SHALL advance by BYTEENABLEWIDTH, unless the fixed flag is set.
REQ-022 On each accepted read, length SHALL decrease by BYTEENABLEWIDTH. If length < BYTEENABLEWIDTH, length SHALL become 0 (no underflow wrap).
REQ-023 pending (FIFODEPTH_LOG2+1 bits) SHALL count accepted reads whose data has not returned:
  - +1 on accept only;
  - -1 on master_readdatavalid only;
  - unchanged when both occur in the same cycle.
REQ-024 Every master_readdatavalid beat SHALL be written into the buffer. The credit rule in REQ-020 guarantees no overflow; no other backpressure exists.
REQ-025 Buffer timing: a word written in cycle N SHALL appear on user_buffer_data with user_data_available=1 in cycle N+1 when the buffer was empty.
REQ-026 user_read_buffer while the buffer is empty SHALL be ignored.
REQ-027 A simultaneous push and pop SHALL leave fifo_used unchanged. Data order SHALL be preserved.
REQ-028 control_done SHALL equal (length == 0) & (pending == 0). Buffered data may still be unread when control_done is high.
REQ-029 master_read SHALL be held, with a stable address, while master_waitrequest=1.

Reset
REQ-030 While reset_n=0 the following SHALL be 0, asynchronously: address, length, fixed flag, pending, and buffer pointers/count.
REQ-031 Output values during reset SHALL be: control_done=1, control_early_done=1, master_read=0, user_data_available=0.
REQ-032 Reset asserted mid-transfer SHALL flush the buffer and discard outstanding reads. Late readdatavalid beats after release SHALL be dropped while pending=0.

Structure
REQ-033 The shared package SHALL hold the default width/depth constants and a clog2 helper. It SHALL be reused by the write-side master.
REQ-034 The buffer SHALL be one sub-module, master_fifo:
  - synchronous, show-ahead;
  - parameterised by width and depth;
  - exposes used count, empty and full.
REQ-035 Counters SHALL be in read_master; no other sub-modules.

Verification
REQ-036 Basic transfer: base 0x100, length 16, waitrequest=0, readdatavalid 2 cycles after accept, user pops continuously -> reads issued at 0x100, 0x104, 0x108, 0x10C; 4 words delivered in order; control_done rises after the 4th beat.
REQ-037 Credit limit: FIFODEPTH=4, length 64, user never pops -> exactly 4 reads accepted; master_read stays 0 until a pop; a pop releases exactly one further read.
REQ-038 Stall: waitrequest=1 for 5 cycles on the 2nd read -> address and master_read stable throughout; length decrements only once on release.
REQ-039 Fixed location and odd length: fixed=1, base 0x40, length 10 -> 3 reads, all at 0x40; length reaches 0 without wrap.
REQ-040 Edge events:
  - accept and readdatavalid in the same cycle -> pending unchanged;
  - control_go while busy -> ignored;
  - reset_n low mid-transfer -> all REQ-031 values hold and the buffer is empty.
